// File: rtl/mem_line_responder_pkg.sv
// Shared types for the line-granular memory bus and the response queue.
package Mem;

  localparam int unsigned LINE_W = 64;
  localparam int unsigned ADDR_W = 16;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [ADDR_W-1:0] lineaddr_t;
  typedef logic [1:0]        busid_t;

  typedef struct packed {
    busid_t    id;
    logic      we;
    lineaddr_t addr;
    line_t     data;
  } busreq_t;

  // Circular-buffer pointer increment; depth need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    int unsigned nxt;
    nxt = ptr + 32'd1;
    if (nxt >= depth) begin
      return 32'd0;
    end else begin
      return nxt;
    end
  endfunction

endpackage

// File: rtl/mem_resp_queue.sv
// Countdown FIFO of pending responses. Each entry holds {id, data, cnt};
// cnt runs down to zero regardless of backpressure, and the head entry is
// presented only once its countdown has expired. Outputs are zero when no
// response is presented.
module mem_resp_queue
  import Mem::*;
#(
  parameter int unsigned QDEPTH  = 8,
  parameter int unsigned LATENCY = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  busid_t push_id,
  input  line_t  push_data,
  input  logic   pop,
  output logic   full,
  output logic   head_valid,
  output busid_t head_id,
  output line_t  head_data
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(LATENCY + 1);
  localparam int unsigned NW = $clog2(QDEPTH + 1);

  logic [QDEPTH-1:0] occ_q, occ_d;
  busid_t            id_q   [QDEPTH];
  busid_t            id_d   [QDEPTH];
  line_t             data_q [QDEPTH];
  line_t             data_d [QDEPTH];
  logic [CW-1:0]     cnt_q  [QDEPTH];
  logic [CW-1:0]     cnt_d  [QDEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [NW-1:0]     count_q, count_d;

  logic push_ok_s;
  logic pop_ok_s;

  assign full       = (count_q == NW'(QDEPTH));
  assign head_valid = occ_q[head_q] && (cnt_q[head_q] == {CW{1'b0}});
  assign head_id    = head_valid ? id_q[head_q]   : 2'b00;
  assign head_data  = head_valid ? data_q[head_q] : {LINE_W{1'b0}};
  assign push_ok_s  = push && !full;
  assign pop_ok_s   = pop && head_valid;

  // Next state: age every occupied entry, retire the head, append at the tail.
  always_comb begin
    occ_d   = occ_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int i = 0; i < QDEPTH; i++) begin
      id_d[i]   = id_q[i];
      data_d[i] = data_q[i];
      if (occ_q[i] && (cnt_q[i] != {CW{1'b0}})) begin
        cnt_d[i] = cnt_q[i] - CW'(32'd1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end

    if (pop_ok_s) begin
      occ_d[head_q] = 1'b0;
      head_d        = PW'(wrap_inc(32'(head_q), QDEPTH));
    end else begin
      head_d = head_q;
    end

    // A full queue never accepts, so the tail slot here is always free.
    if (push_ok_s) begin
      occ_d[tail_q]  = 1'b1;
      id_d[tail_q]   = push_id;
      data_d[tail_q] = push_data;
      cnt_d[tail_q]  = CW'(LATENCY - 32'd1);
      tail_d         = PW'(wrap_inc(32'(tail_q), QDEPTH));
    end else begin
      tail_d = tail_q;
    end

    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + NW'(32'd1);
      2'b01:   count_d = count_q - NW'(32'd1);
      default: count_d = count_q;
    endcase
  end

  // Queue state register; reset drops every outstanding entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q   <= {QDEPTH{1'b0}};
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {NW{1'b0}};
      for (int i = 0; i < QDEPTH; i++) begin
        id_q[i]   <= 2'b00;
        data_q[i] <= {LINE_W{1'b0}};
        cnt_q[i]  <= {CW{1'b0}};
      end
    end else begin
      occ_q   <= occ_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < QDEPTH; i++) begin
        id_q[i]   <= id_d[i];
        data_q[i] <= data_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

endmodule

// File: rtl/mem_line_responder.sv
// Backing memory for line refills/writebacks: a line array with fixed
// response latency and in-order, id-tagged responses (one per request).
module mem_line_responder
  import Mem::*;
#(
  parameter int unsigned LINES     = 256,
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned QDEPTH    = 8,
  parameter string       INIT_FILE = ""
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      req_valid,
  output logic      req_ready,
  input  busid_t    req_id,
  input  logic      req_we,
  input  lineaddr_t req_addr,
  input  line_t     req_data,
  output logic      resp_valid,
  input  logic      resp_ready,
  output busid_t    resp_id,
  output line_t     resp_data
);

  localparam int unsigned IW = $clog2(LINES);

  // The array is deliberately outside the reset domain: contents survive reset.
  line_t mem_q [LINES];

  busreq_t       req_s;
  logic [IW-1:0] idx_s;
  logic          accept_s;
  logic          wr_en_s;
  line_t         push_data_s;
  logic          full_s;
  logic          head_valid_s;
  logic          ready_en_q, ready_en_d;
  logic          unused_addr_hi_s;

  assign req_s            = '{id: req_id, we: req_we, addr: req_addr, data: req_data};
  // Upper address bits are dropped, so addresses alias modulo LINES.
  assign idx_s            = req_s.addr[IW-1:0];
  assign unused_addr_hi_s = ^req_s.addr[ADDR_W-1:IW];

  // Ready depends only on registered state; held low until the first edge after reset.
  assign req_ready = ready_en_q && !full_s;
  assign accept_s  = req_valid && req_ready;
  assign wr_en_s   = accept_s && req_s.we;

  // Data queued for the response: the written line, or the array contents at accept.
  always_comb begin
    push_data_s = {LINE_W{1'b0}};
    if (req_s.we) begin
      push_data_s = req_s.data;
    end else begin
      push_data_s = mem_q[idx_s];
    end
  end

  // Ready enable becomes set on the first clock after reset release.
  always_comb begin
    ready_en_d = 1'b1;
  end

  // Ready enable register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= ready_en_d;
    end
  end

  // Line array write port; the write lands on the accept edge.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[idx_s] <= req_s.data;
    end
  end

  mem_resp_queue #(
    .QDEPTH  (QDEPTH),
    .LATENCY (LATENCY)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst),
    .push       (accept_s),
    .push_id    (req_s.id),
    .push_data  (push_data_s),
    .pop        (resp_ready),
    .full       (full_s),
    .head_valid (head_valid_s),
    .head_id    (resp_id),
    .head_data  (resp_data)
  );

  assign resp_valid = head_valid_s;

endmodule
